// File: rtl/lane_pixel_generator.sv
// Frogger lane pixel source: per-lane scroll state, 2-stage colour pipeline,
// per-frame frog collision. Define LANE_GRID_EN to draw grey lane dividers.
module lane_pixel_generator #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int LANES     = 15,
    parameter int FROG_SIZE = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  frog_x,
    input  logic [9:0]  frog_y,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_lane,
    input  logic [1:0]  cfg_type,
    input  logic        cfg_dir,
    input  logic [3:0]  cfg_speed,
    input  logic [19:0] cfg_pattern,
    output logic [5:0]  colorcode,
    output logic        cc_valid,
    output logic        frog_hit
);

    localparam logic [1:0] T_GRASS = 2'd0;
    localparam logic [1:0] T_ROAD  = 2'd1;
    localparam logic [1:0] T_WATER = 2'd2;
    localparam logic [1:0] T_GOAL  = 2'd3;

    localparam logic [9:0]  OFF_MAX = 10'(H_ACTIVE - 1);
    localparam logic [10:0] H_W     = 11'(H_ACTIVE);
    localparam logic [10:0] FROG_W  = 11'(FROG_SIZE - 1);
    localparam logic [10:0] FROG_C  = 11'(FROG_SIZE / 2);

    // per-lane configuration and scroll state
    logic [1:0]  type_q [LANES];
    logic [1:0]  type_d [LANES];
    logic [19:0] pat_q  [LANES];
    logic [19:0] pat_d  [LANES];
    logic [3:0]  speed_q[LANES];
    logic [3:0]  speed_d[LANES];
    logic        dir_q  [LANES];
    logic        dir_d  [LANES];
    logic [9:0]  off_q  [LANES];
    logic [9:0]  off_d  [LANES];
    logic [3:0]  sub_q  [LANES];
    logic [3:0]  sub_d  [LANES];

    logic        frame_q;
    logic        frame_start;

    // stage 1
    logic        s1_valid_q, s1_valid_d;
    logic [9:0]  s1_x_q, s1_x_d;
    logic [9:0]  s1_y_q, s1_y_d;
    logic [1:0]  s1_type_q, s1_type_d;
    logic [19:0] s1_pat_q, s1_pat_d;
    logic        s1_dir_q, s1_dir_d;
    logic [9:0]  s1_off_q, s1_off_d;
    logic [3:0]  sel_lane;

    // stage 2 and frame results
    logic [5:0]  colorcode_q, colorcode_d;
    logic        cc_valid_q, cc_valid_d;
    logic        pending_q, pending_d;
    logic        frog_hit_q, frog_hit_d;

    logic [10:0] sum;
    logic [10:0] xp;
    logic [4:0]  tile;
    logic [31:0] pat_ext;
    logic        obst;
    logic        offscreen;
    logic        in_frog;
    logic        at_centre;
    logic        hit_now;
    logic        divider;

    assign frame_start = frame_clk & ~frame_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            type_d[i]  = type_q[i];
            pat_d[i]   = pat_q[i];
            speed_d[i] = speed_q[i];
            dir_d[i]   = dir_q[i];
            off_d[i]   = off_q[i];
            sub_d[i]   = sub_q[i];
            if (frame_start && speed_q[i] != 4'd0) begin
                if (sub_q[i] == speed_q[i] - 4'd1) begin
                    sub_d[i] = 4'd0;
                    off_d[i] = (off_q[i] == OFF_MAX) ? 10'd0
                                                     : off_q[i] + 10'd1;
                end else begin
                    sub_d[i] = sub_q[i] + 4'd1;
                end
            end
            // a write overrides any scroll step on the same lane
            if (cfg_we && cfg_lane == 4'(i)) begin
                type_d[i]  = cfg_type;
                pat_d[i]   = cfg_pattern;
                speed_d[i] = cfg_speed;
                dir_d[i]   = cfg_dir;
                off_d[i]   = off_q[i];
                sub_d[i]   = 4'd0;
            end
        end
    end

    always_comb begin
        sel_lane = (DrawY[9:5] < 5'(LANES)) ? DrawY[8:5] : 4'd0;
        s1_valid_d = pix_valid;
        s1_x_d     = DrawX;
        s1_y_d     = DrawY;
        s1_type_d  = type_q[sel_lane];
        s1_pat_d   = pat_q[sel_lane];
        s1_dir_d   = dir_q[sel_lane];
        s1_off_d   = off_q[sel_lane];
    end

    always_comb begin
        sum = {1'b0, s1_x_q} + {1'b0, s1_off_q};
        xp  = '0;
        if (!s1_dir_q) begin
            xp = (sum >= H_W) ? sum - H_W : sum;
        end else if (s1_x_q >= s1_off_q) begin
            xp = {1'b0, s1_x_q} - {1'b0, s1_off_q};
        end else begin
            xp = {1'b0, s1_x_q} + H_W - {1'b0, s1_off_q};
        end
        tile    = xp[9:5];
        pat_ext = {12'd0, s1_pat_q};
        obst    = pat_ext[tile];

        offscreen = (s1_x_q >= 10'(H_ACTIVE)) || (s1_y_q >= 10'(V_ACTIVE));
        in_frog = ({1'b0, s1_x_q} >= {1'b0, frog_x})
               && ({1'b0, s1_x_q} <= {1'b0, frog_x} + FROG_W)
               && ({1'b0, s1_y_q} >= {1'b0, frog_y})
               && ({1'b0, s1_y_q} <= {1'b0, frog_y} + FROG_W);
        at_centre = ({1'b0, s1_x_q} == {1'b0, frog_x} + FROG_C)
                 && ({1'b0, s1_y_q} == {1'b0, frog_y} + FROG_C);
        hit_now = s1_valid_q && !offscreen && at_centre
               && ((s1_type_q == T_ROAD && obst)
                || (s1_type_q == T_WATER && !obst));

`ifdef LANE_GRID_EN
        divider = (s1_y_q[4:0] == 5'd0);
`else
        divider = 1'b0;
`endif

        colorcode_d = 6'd1;
        if (offscreen) begin
            colorcode_d = 6'd1;
        end else if (in_frog) begin
            colorcode_d = 6'd5;
        end else if (divider) begin
            colorcode_d = 6'd6;
        end else if (obst) begin
            unique case (s1_type_q)
                T_GRASS: colorcode_d = 6'd6;
                T_ROAD:  colorcode_d = 6'd3;
                T_WATER: colorcode_d = 6'd8;
                T_GOAL:  colorcode_d = 6'd0;
                default: colorcode_d = 6'd1;
            endcase
        end else begin
            unique case (s1_type_q)
                T_GRASS: colorcode_d = 6'd2;
                T_ROAD:  colorcode_d = 6'd1;
                T_WATER: colorcode_d = 6'd4;
                T_GOAL:  colorcode_d = 6'd7;
                default: colorcode_d = 6'd1;
            endcase
        end
        cc_valid_d = s1_valid_q;

        // a centre hit on the frame_start cycle belongs to the new frame
        pending_d  = frame_start ? hit_now : (pending_q | hit_now);
        frog_hit_d = frame_start ? pending_q : frog_hit_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                type_q[i]  <= T_GRASS;
                pat_q[i]   <= '0;
                speed_q[i] <= '0;
                dir_q[i]   <= 1'b0;
                off_q[i]   <= '0;
                sub_q[i]   <= '0;
            end
            frame_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_type_q   <= T_GRASS;
            s1_pat_q    <= '0;
            s1_dir_q    <= 1'b0;
            s1_off_q    <= '0;
            colorcode_q <= 6'd1;
            cc_valid_q  <= 1'b0;
            pending_q   <= 1'b0;
            frog_hit_q  <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                type_q[i]  <= type_d[i];
                pat_q[i]   <= pat_d[i];
                speed_q[i] <= speed_d[i];
                dir_q[i]   <= dir_d[i];
                off_q[i]   <= off_d[i];
                sub_q[i]   <= sub_d[i];
            end
            frame_q     <= frame_clk;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_type_q   <= s1_type_d;
            s1_pat_q    <= s1_pat_d;
            s1_dir_q    <= s1_dir_d;
            s1_off_q    <= s1_off_d;
            colorcode_q <= colorcode_d;
            cc_valid_q  <= cc_valid_d;
            pending_q   <= pending_d;
            frog_hit_q  <= frog_hit_d;
        end
    end

    assign colorcode = colorcode_q;
    assign cc_valid  = cc_valid_q;
    assign frog_hit  = frog_hit_q;

endmodule

// File: tb/tb_lane_pixel_generator.sv
// Scoreboard bench for lane_pixel_generator: directed pixels push expected
// colour codes; a monitor pops and compares whenever cc_valid is high.
module tb_lane_pixel_generator;

`ifdef LANE_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY, frog_x, frog_y;
    logic        cfg_we;
    logic [3:0]  cfg_lane;
    logic [1:0]  cfg_type;
    logic        cfg_dir;
    logic [3:0]  cfg_speed;
    logic [19:0] cfg_pattern;
    logic [5:0]  colorcode;
    logic        cc_valid;
    logic        frog_hit;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    int         id_q[$];
    int         pix_id = 0;

    lane_pixel_generator dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .frog_x(frog_x), .frog_y(frog_y), .cfg_we(cfg_we),
        .cfg_lane(cfg_lane), .cfg_type(cfg_type), .cfg_dir(cfg_dir),
        .cfg_speed(cfg_speed), .cfg_pattern(cfg_pattern),
        .colorcode(colorcode), .cc_valid(cc_valid), .frog_hit(frog_hit)
    );

    always #5 Clk = ~Clk;

    // monitor
    always @(posedge Clk) begin
        #1;
        if (cc_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid colorcode got %0d want none",
                         colorcode);
            end else begin
                logic [5:0] e;
                int id;
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                if (colorcode !== e) begin
                    errors++;
                    $display("FAIL pix%0d colorcode got %0d want %0d",
                             id, colorcode, e);
                end
            end
        end
    end

    task automatic send(input int x, input int y, input int e);
        @(negedge Clk);
        pix_valid = 1'b1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        exp_q.push_back(6'(e));
        id_q.push_back(pix_id);
        pix_id++;
    endtask

    task automatic flush();
        @(negedge Clk);
        pix_valid = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic cfg(input int lane, input int ty, input int dir,
                       input int spd, input int pat);
        @(negedge Clk);
        cfg_we = 1'b1;
        cfg_lane = 4'(lane);
        cfg_type = 2'(ty);
        cfg_dir = 1'(dir);
        cfg_speed = 4'(spd);
        cfg_pattern = 20'(pat);
        @(negedge Clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse();
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic sweep(input int patbit);
        for (int x = 92; x <= 135; x++) begin
            int e;
            if (x >= 100 && x <= 131) e = 5;
            else if (patbit != 0 && x >= 96 && x <= 127) e = 8;
            else e = 4;
            send(x, 112, e);
        end
        flush();
    endtask

    initial begin
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        pix_valid = 1'b1;
        DrawX = '0;
        DrawY = '0;
        frog_x = 10'd300;
        frog_y = 10'd300;
        cfg_we = 1'b0;
        cfg_lane = '0;
        cfg_type = '0;
        cfg_dir = 1'b0;
        cfg_speed = '0;
        cfg_pattern = '0;
        repeat (3) @(negedge Clk);
        check("rst_colorcode", int'(colorcode), 1);
        check("rst_cc_valid", int'(cc_valid), 0);
        check("rst_frog_hit", int'(frog_hit), 0);

        // first pixel held through reset release
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_q.push_back(GRID ? 6'd6 : 6'd2);
        id_q.push_back(pix_id);
        pix_id++;
        send(50, 65, 2);
        send(50, 64, GRID ? 6 : 2);
        flush();
        check("post_rst_frog_hit", int'(frog_hit), 0);
        frog_x = 10'd40;
        frog_y = 10'd60;
        send(50, 64, 5);
        flush();

        // lane 5 road, one obstacle tile, speed 1
        frog_x = 10'd0;
        frog_y = 10'd0;
        cfg(5, 1, 0, 1, 20'h00001);
        send(0, 161, 3);
        send(32, 161, 1);
        send(700, 161, 1);
        send(0, 500, 1);
        send(10, 10, 5);
        send(40, 10, 2);
        flush();

        repeat (32) pulse();
        check("frog_hit_no_centre", int'(frog_hit), 0);
        send(0, 161, 1);
        send(608, 161, 3);
        flush();
        cfg(5, 1, 1, 0, 20'h00001);
        send(32, 161, 3);
        send(0, 161, 1);
        flush();
        cfg(15, 1, 0, 0, 20'hFFFFF);
        send(200, 5, 2);
        send(200, 479, 2);
        flush();

        // water lane 3 collision
        frog_x = 10'd100;
        frog_y = 10'd96;
        cfg(3, 2, 0, 0, 0);
        sweep(0);
        check("hit_before_edge", int'(frog_hit), 0);
        pulse();
        check("water_clear_hit", int'(frog_hit), 1);
        pulse();
        check("not_drawn_hit", int'(frog_hit), 0);
        sweep(0);
        check("hit_held_until_edge", int'(frog_hit), 0);
        pulse();
        check("water_clear_hit2", int'(frog_hit), 1);
        cfg(3, 2, 0, 0, 20'h00008);
        sweep(1);
        pulse();
        check("water_log_hit", int'(frog_hit), 0);

        // lane 2 write coinciding with frame_start
        frog_x = 10'd300;
        frog_y = 10'd300;
        @(negedge Clk);
        frame_clk = 1'b1;
        cfg_we = 1'b1;
        cfg_lane = 4'd2;
        cfg_type = 2'd1;
        cfg_dir = 1'b0;
        cfg_speed = 4'd3;
        cfg_pattern = 20'h00001;
        @(negedge Clk);
        frame_clk = 1'b0;
        cfg_we = 1'b0;
        send(639, 70, 1);
        send(0, 70, 3);
        flush();
        pulse();
        pulse();
        send(639, 70, 1);
        flush();
        pulse();
        send(639, 70, 3);
        flush();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge Clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
